i2s_tx: RTL and testbench

- I2S transmitter (DAC side): the output direction of the existing i2s receiver.
- Accepts stereo sample pairs over a valid/ready handshake and double-buffers them.
- Generates scki, bck and lrck itself and serialises the samples MSB-first on dout.
- Sits between the audio/FFT processing output and the external codec DAC.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_clkgen.sv | 53 +++++
 rtl/i2s_tx.sv | 102 ++++++++++
 tb/tb_i2s_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmitter and receiver: default geometry and stereo sample types.
package i2s_pkg;

   localparam int WIDTH_DEF = 24;
   localparam int SLOT_DEF  = 32;

   typedef logic signed [WIDTH_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S frame timing: frame counter plus registered scki/bck/lrck, aligned to cnt; exports bit index, phase and frame_end.
// I2S_TX_LEFT_JUSTIFIED_EN inverts lrck (1 = left).
module i2s_clkgen import i2s_pkg::*; #(
   parameter  int SLOT        = SLOT_DEF,
   parameter  int CLK_PER_BCK = 8,
   localparam int FRAME       = 2 * SLOT * CLK_PER_BCK,
   localparam int CW          = $clog2(FRAME),
   localparam int PW          = $clog2(CLK_PER_BCK),
   localparam int BW          = CW - PW
) (
   input  logic          clk,
   input  logic          reset,
   output logic [BW-1:0] b,
   output logic [PW-1:0] p,
   output logic          frame_end,
   output logic          scki,
   output logic          bck,
   output logic          lrck
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [BW-1:0] b_nxt;
   logic          lrck_nxt;

   assign frame_end = (cnt == CW'(FRAME - 1));
   assign cnt_nxt   = frame_end ? '0 : cnt + CW'(1);
   assign b_nxt     = cnt_nxt[CW-1:PW];
   assign b         = cnt[CW-1:PW];
   assign p         = cnt[PW-1:0];

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   assign lrck_nxt = (b_nxt < BW'(SLOT));
`else
   assign lrck_nxt = (b_nxt >= BW'(SLOT));
`endif

   // Clock outputs are decoded from the next count so they line up with cnt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt  <= '0;
         scki <= 1'b0;
         bck  <= 1'b0;
         lrck <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         scki <= cnt_nxt[0];
         bck  <= cnt_nxt[PW-1];
         lrck <= lrck_nxt;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: hold + active double buffer, MSB-first serialisation; left MSB on dout at cnt==CLK_PER_BCK of the frame after acceptance.
// sample_ready is low while the hold register is full; I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing.
module i2s_tx import i2s_pkg::*; #(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int SLOT        = SLOT_DEF,
   parameter int CLK_PER_BCK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic             dout,
   output logic             bck,
   output logic             lrck,
   output logic             scki,
   output logic             underrun
);

   localparam int PW = $clog2(CLK_PER_BCK);
   localparam int BW = $clog2(2 * SLOT);

   typedef struct packed {
      logic signed [WIDTH-1:0] left;
      logic signed [WIDTH-1:0] right;
   } pair_t;

   logic [BW-1:0]    b;
   logic [PW-1:0]    p;
   logic             frame_end;
   logic             hold_full;
   logic             hold_full_nxt;
   logic             accept;
   pair_t            hold;
   pair_t            active;
   pair_t            active_nxt;
   logic [BW-1:0]    b_nxt;
   logic [BW-1:0]    s_nxt;
   logic             right_nxt;
   logic [WIDTH-1:0] word_nxt;
   logic [WIDTH-1:0] shifted;
   logic             in_range;
   logic             bit_nxt;

   i2s_clkgen #(
      .SLOT        (SLOT),
      .CLK_PER_BCK (CLK_PER_BCK)
   ) u_clkgen (
      .clk       (clk),
      .reset     (reset),
      .b         (b),
      .p         (p),
      .frame_end (frame_end),
      .scki      (scki),
      .bck       (bck),
      .lrck      (lrck)
   );

   assign accept        = sample_valid && sample_ready;
   assign hold_full_nxt = accept || (hold_full && !frame_end);

   always_comb begin
      active_nxt = active;
      if (frame_end) active_nxt = hold_full ? hold : '0;
   end

   // Next bit position; only consumed on the last phase of a bck period.
   assign b_nxt     = frame_end ? '0 : b + BW'(1);
   assign right_nxt = (b_nxt >= BW'(SLOT));
   assign s_nxt     = right_nxt ? b_nxt - BW'(SLOT) : b_nxt;
   assign word_nxt  = right_nxt ? active_nxt.right : active_nxt.left;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   assign shifted  = word_nxt << s_nxt;
   assign in_range = (s_nxt < BW'(WIDTH));
`else
   assign shifted  = word_nxt << (s_nxt - BW'(1));
   assign in_range = (s_nxt != '0) && (s_nxt <= BW'(WIDTH));
`endif

   assign bit_nxt = in_range && shifted[WIDTH-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold         <= '0;
         active       <= '0;
         hold_full    <= 1'b0;
         sample_ready <= 1'b0;
         underrun     <= 1'b0;
         dout         <= 1'b0;
      end else begin
         if (accept) hold <= {left, right};
         hold_full    <= hold_full_nxt;
         sample_ready <= !hold_full_nxt;
         active       <= active_nxt;
         underrun     <= frame_end && !hold_full;
         if (p == PW'(CLK_PER_BCK - 1)) dout <= bit_nxt;
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at default parameters; frames are captured the way a DAC would see them.
module tb_i2s_tx;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   localparam bit LJ = 1'b1;
`else
   localparam bit LJ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic        sample_ready;
   logic [23:0] left;
   logic [23:0] right;
   logic        dout;
   logic        bck;
   logic        lrck;
   logic        scki;
   logic        underrun;

   int nvec = 0;
   int nerr = 0;
   int c    = 0;
   logic [47:0] pend[$];
   logic [47:0] stage[$];

   i2s_tx dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .left         (left),
      .right        (right),
      .dout         (dout),
      .bck          (bck),
      .lrck         (lrck),
      .scki         (scki),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fw(input logic [47:0] pr);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      return {pr[47:24], 8'h00, pr[23:0], 8'h00};
`else
      return {1'b0, pr[47:24], 7'h00, 1'b0, pr[23:0], 7'h00};
`endif
   endfunction

   task automatic push(input logic [47:0] pr);
      if (!sample_valid) begin
         {left, right} = pr;
         sample_valid  = 1'b1;
      end else begin
         pend.push_back(pr);
      end
   endtask

   // One clk; c tracks the expected frame position after release.
   task automatic tick();
      logic acc;
      acc = sample_valid && sample_ready;
      @(posedge clk);
      #1;
      c = (c + 1) % 512;
      if (acc) begin
         if (pend.size() > 0) {left, right} = pend.pop_front();
         else sample_valid = 1'b0;
      end
   endtask

   task automatic play_frame(input string tag, input logic [47:0] pr, input logic exp_ur,
                             input logic exp_r0, input logic exp_r1, input int push_at);
      logic [63:0] a;
      logic [63:0] z;
      int          urn;
      logic        ur0;
      logic        r0;
      logic        r1;
      a = '0; z = '0; urn = 0; ur0 = 1'b0; r0 = 1'b0; r1 = 1'b0;
      for (int i = 0; i < 512; i++) begin
         if (c % 8 == 1) a[63 - c / 8] = dout;
         if (c % 8 == 7) z[63 - c / 8] = dout;
         if (underrun === 1'b1) urn++;
         if (c == 0) begin
            ur0 = underrun;
            r0  = sample_ready;
         end
         if (c == 1) r1 = sample_ready;
         if (c == push_at) begin
            chk({tag, " ready before push"}, 64'(sample_ready), 64'(1));
            while (stage.size() > 0) push(stage.pop_front());
         end
         if (push_at >= 0 && c == push_at + 1)
            chk({tag, " ready after push"}, 64'(sample_ready), 64'(0));
         tick();
      end
      chk({tag, " underrun at cnt0"}, 64'(ur0), 64'(exp_ur));
      chk({tag, " underrun pulse count"}, 64'(urn), 64'(exp_ur));
      chk({tag, " ready at cnt0"}, 64'(r0), 64'(exp_r0));
      chk({tag, " ready at cnt1"}, 64'(r1), 64'(exp_r1));
      chk({tag, " data early in bck"}, a, fw(pr));
      chk({tag, " data late in bck"}, z, fw(pr));
   endtask

   initial begin
      logic [3:0] e;

      reset        = 1'b0;
      sample_valid = 1'b1;
      left         = '1;
      right        = '1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("outputs in reset", 64'({dout, bck, lrck, scki, underrun, sample_ready}), 64'(0));
      end

      reset        = 1'b1;
      sample_valid = 1'b0;
      c            = 0;
      chk("outputs at release", 64'({dout, bck, lrck, scki, underrun, sample_ready}), 64'(0));
      tick();
      chk("ready after release", 64'(sample_ready), 64'(1));

      // Free-running frame: scki/bck/lrck against their cnt definitions.
      for (int i = 1; i < 512; i++) begin
         e = {c[0], (c % 8) >= 4, (c >= 256) != LJ, 1'b0};
         chk("clocks frame0", 64'({scki, bck, lrck, underrun}), 64'(e));
         tick();
      end
      chk("lrck wraps at 512", 64'(lrck), 64'(LJ));

      stage.push_back({24'hA5A5A5, 24'h123456});
      play_frame("frame1 empty", 48'h0, 1'b1, 1'b1, 1'b1, 10);

      stage.push_back({24'h800001, 24'h7FFFFF});
      stage.push_back({24'hFFFFFF, 24'h000001});
      stage.push_back({24'h5A5A5A, 24'hC3C3C3});
      play_frame("frame2 A5", {24'hA5A5A5, 24'h123456}, 1'b0, 1'b1, 1'b1, 20);
      play_frame("frame3 pair1", {24'h800001, 24'h7FFFFF}, 1'b0, 1'b1, 1'b0, -1);
      play_frame("frame4 pair2", {24'hFFFFFF, 24'h000001}, 1'b0, 1'b1, 1'b0, -1);
      play_frame("frame5 pair3", {24'h5A5A5A, 24'hC3C3C3}, 1'b0, 1'b1, 1'b1, -1);

      stage.push_back({24'h0F0F0F, 24'hF0F0F0});
      play_frame("frame6 stall", 48'h0, 1'b1, 1'b1, 1'b1, 30);

      while (c != 100) tick();
      push({24'h111111, 24'h222222});
      while (c != 300) tick();
      chk("hold full at cnt300", 64'(sample_ready), 64'(0));
      chk("bck/lrck at cnt300", 64'({bck, lrck}), 64'({1'b1, !LJ}));
      reset = 1'b0;
      tick();
      chk("outputs after mid-frame reset", 64'({dout, bck, lrck, scki, underrun, sample_ready}), 64'(0));
      tick();
      reset = 1'b1;
      c     = 0;
      chk("outputs at second release", 64'({dout, bck, lrck, scki, underrun, sample_ready}), 64'(0));
      play_frame("restart frame", 48'h0, 1'b0, 1'b0, 1'b1, -1);
      play_frame("first boundary after reset", 48'h0, 1'b1, 1'b1, 1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
